// File: rtl/ntt_pkg.sv
// ntt_pkg: shared types and constants for the simple_ntt stream driver.
// Holds the driver state enum, err_code values and default geometry.
package ntt_pkg;
  localparam int NTT_DATA_WIDTH = 32;
  localparam int NTT_FRAME_LEN = 4;
  localparam logic [1:0] NTT_ERR_NONE = 2'd0;
  localparam logic [1:0] NTT_ERR_REJECT = 2'd1;
  localparam logic [1:0] NTT_ERR_TIMEOUT = 2'd2;
  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SEND,
    GAP,
    COLLECT,
    WAIT_RDY
  } ntt_drv_state_t;
endpackage

// File: rtl/ntt_drv_buf.sv
// ntt_drv_buf: DEPTH x DW register array, one write port, one registered read port.
// Ports: clk, reset (async active-low, clears the read register only),
//   we/waddr/wdata write port; re/raddr read request; rdata read word one cycle
//   later, or 0 when re was low.
module ntt_drv_buf
  import ntt_pkg::*;
#(
  parameter int DW = NTT_DATA_WIDTH,
  parameter int DEPTH = NTT_FRAME_LEN,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // A low re zeroes the output so the tx copy can drive in_stream directly.
  always_ff @(posedge clk or negedge reset)
    if (!reset) rdata <= '0;
    else rdata <= re ? mem[raddr] : '0;
endmodule

// File: rtl/ntt_stream_driver.sv
// ntt_stream_driver: host-side initiator that streams one tx frame into simple_ntt
// and captures the returned frame into an rx buffer.
// Ports: clk, reset (async active-low); host side wr_en/wr_addr/wr_data (tx load,
//   IDLE only), go, rd_addr/rd_data (rx read, 1-cycle latency), busy, done, err,
//   err_code; downstream side start, in_stream, ready, out_stream.
// Optional watchdog on ARM/WAIT_RDY: define NTT_DRV_TIMEOUT_EN.
module ntt_stream_driver
  import ntt_pkg::*;
#(
  parameter int DATA_WIDTH = NTT_DATA_WIDTH,
  parameter int FRAME_LEN = NTT_FRAME_LEN,
  parameter int TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [$clog2(FRAME_LEN)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         go,
  input  logic [$clog2(FRAME_LEN)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [1:0]                   err_code,
  output logic                         start,
  output logic [DATA_WIDTH-1:0]        in_stream,
  input  logic                         ready,
  input  logic [DATA_WIDTH-1:0]        out_stream
);
  localparam int AW = $clog2(FRAME_LEN);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);
  ntt_drv_state_t state, nxt;
  logic [CW-1:0] cnt, cnt_d;
  logic start_d, done_d, err_d;
  logic [1:0] code_d;
  logic tx_re;
  logic [AW-1:0] tx_ra;
  logic wd_hit;
`ifdef NTT_DRV_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
  // Counts consecutive cycles in the current ARM or WAIT_RDY visit.
  always_ff @(posedge clk or negedge reset)
    if (!reset) wd <= '0;
    else wd <= ((state == ARM || state == WAIT_RDY) && nxt == state) ? wd + 1'b1 : '0;
  assign wd_hit = wd == WW'(TIMEOUT - 1);
`else
  assign wd_hit = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= NTT_ERR_NONE;
    end else begin
      state <= nxt;
      cnt <= cnt_d;
      start <= start_d;
      busy <= nxt != IDLE;
      done <= done_d;
      err <= err_d;
      err_code <= code_d;
    end
  // tx is read one cycle ahead: the word for cycle Ck is fetched in C(k-1).
  always_comb begin
    nxt = state;
    cnt_d = cnt;
    done_d = 1'b0;
    err_d = 1'b0;
    code_d = err_code;
    tx_re = 1'b0;
    tx_ra = AW'(cnt + 1'b1);
    case (state)
      IDLE:
        if (go) begin
          nxt = ARM;
          code_d = NTT_ERR_NONE;
        end
      ARM:
        if (ready) begin
          nxt = SEND;
          cnt_d = '0;
          tx_re = 1'b1;
          tx_ra = '0;
        end else if (wd_hit) begin
          nxt = IDLE;
          err_d = 1'b1;
          code_d = NTT_ERR_TIMEOUT;
        end
      SEND:
        if (cnt == '0 && ready) begin
          nxt = IDLE;
          err_d = 1'b1;
          code_d = NTT_ERR_REJECT;
        end else if (cnt == LAST) begin
          nxt = GAP;
        end else begin
          cnt_d = cnt + 1'b1;
          tx_re = 1'b1;
        end
      GAP: begin
        nxt = COLLECT;
        cnt_d = '0;
      end
      COLLECT: begin
        nxt = cnt == LAST ? WAIT_RDY : COLLECT;
        cnt_d = cnt == LAST ? cnt : cnt + 1'b1;
      end
      WAIT_RDY:
        if (ready) begin
          nxt = IDLE;
          done_d = 1'b1;
        end else if (wd_hit) begin
          nxt = IDLE;
          err_d = 1'b1;
          code_d = NTT_ERR_TIMEOUT;
        end
      default: nxt = IDLE;
    endcase
    start_d = nxt == ARM;
  end
  ntt_drv_buf #(.DW(DATA_WIDTH), .DEPTH(FRAME_LEN), .AW(AW)) u_tx (
    .clk(clk),
    .reset(reset),
    .we(wr_en && state == IDLE),
    .waddr(wr_addr),
    .wdata(wr_data),
    .re(tx_re),
    .raddr(tx_ra),
    .rdata(in_stream)
  );
  ntt_drv_buf #(.DW(DATA_WIDTH), .DEPTH(FRAME_LEN), .AW(AW)) u_rx (
    .clk(clk),
    .reset(reset),
    .we(state == COLLECT),
    .waddr(cnt[AW-1:0]),
    .wdata(out_stream),
    .re(1'b1),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_ntt_stream_driver.sv
// tb_ntt_stream_driver: self-checking bench for ntt_stream_driver with a cycle-stepped simple_ntt model.
module tb_ntt_stream_driver;
  localparam int N = 4;
  localparam int DW = 32;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wr_en = 1'b0;
  logic go = 1'b0;
  logic ready = 1'b1;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] out_stream = '0;
  logic [DW-1:0] rd_data, in_stream;
  logic busy, done, err, start;
  logic [1:0] err_code;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] rx_q[$];
  typedef struct {
    logic [N-1:0][DW-1:0] w;
    int hold;
    int tail;
    bit stuck;
    bit prot;
    logic [1:0] code;
    int lat;
  } vec_t;
  vec_t vecs[4];
  ntt_stream_driver #(.DATA_WIDTH(DW), .FRAME_LEN(N), .TIMEOUT(8)) dut (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .go(go),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .busy(busy),
    .done(done),
    .err(err),
    .err_code(err_code),
    .start(start),
    .in_stream(in_stream),
    .ready(ready),
    .out_stream(out_stream)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [DW-1:0] a, b, c, d, input int hold, tail,
                              input bit stuck, prot, input logic [1:0] code, input int lat);
    vec_t v;
    v.w[0] = a;
    v.w[1] = b;
    v.w[2] = c;
    v.w[3] = d;
    v.hold = hold;
    v.tail = tail;
    v.stuck = stuck;
    v.prot = prot;
    v.code = code;
    v.lat = lat;
    return v;
  endfunction
  task automatic load(input vec_t v);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_addr = AW'(k);
      wr_data = v.w[k];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  // Plays simple_ntt around one frame; called at a negedge, go is raised here.
  task automatic frame(input vec_t v);
    int t = 0;
    int c0 = -1;
    int r;
    bit fin = 1'b0;
    for (int k = 0; k < N; k++) exp_q.push_back(v.w[k]);
    go = 1'b1;
    while (!fin && t < 200) begin
      @(negedge clk);
      t++;
      go = 1'b0;
      wr_en = 1'b0;
      r = c0 < 0 ? -1 : t - c0;
      if (c0 < 0) begin
        chk("arm_start", start, 1);
        chk("arm_busy", busy, 1);
        chk("arm_in_stream", in_stream, 0);
        if (t == 1) chk("arm_code_cleared", err_code, 0);
        ready = (t > v.hold) || v.stuck;
        if (ready) c0 = t;
        if (v.prot && t == 1) go = 1'b1;
      end else if (r <= N && !(v.stuck && r == 2)) begin
        chk("send_start", start, 0);
        chk("send_word", in_stream, exp_q.pop_front());
        ready = v.stuck;
        if (v.prot && r == 1) begin
          wr_en = 1'b1;
          wr_addr = 2'd3;
          wr_data = 32'hDEAD_BEEF;
          go = 1'b1;
        end
      end else if (v.stuck) begin
        chk("reject_err", err, 1);
        chk("reject_code", err_code, v.code);
        chk("reject_busy", busy, 0);
        chk("reject_latency", DW'(t - 1), DW'(v.lat));
        exp_q.delete();
        fin = 1'b1;
      end else if (r == N + 1) begin
        chk("gap_in_stream", in_stream, 0);
      end else if (r <= 2 * N + 1) begin
        out_stream = v.w[r-N-2];
        rx_q.push_back(v.w[r-N-2]);
      end else if (r == 2 * N + 3 + v.tail) begin
        chk("done_pulse", done, 1);
        chk("done_err", err, 0);
        chk("done_code", err_code, v.code);
        chk("done_busy", busy, 0);
        chk("done_latency", DW'(t - 1), DW'(v.lat));
        fin = 1'b1;
      end else begin
        chk("early_done", done, 0);
        ready = r >= 2 * N + 2 + v.tail;
      end
    end
    chk("frame_finished", fin, 1);
  endtask
  task automatic readback();
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      rd_addr = AW'(k);
      @(negedge clk);
      chk("rx_word", rd_data, rx_q.pop_front());
    end
  endtask
  initial begin
    bit quiet;
    bit saw_err;
    vecs[0] = mk(32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0, 2'd0, 11);
    vecs[1] = mk(32'h11, 32'h22, 32'h33, 32'h44, 5, 0, 0, 0, 2'd0, 16);
    vecs[2] = mk(32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_FFFF, 32'h0, 2, 3, 0, 1, 2'd0, 16);
    vecs[3] = mk(32'h0BAD_0001, 32'h0BAD_0002, 32'h0BAD_0003, 32'h0BAD_0004, 0, 0, 1, 0, 2'd1, 2);
    #2 reset = 1'b0;
    #1;
    chk("reset_ctrl", {start, busy, done, err, err_code}, 0);
    chk("reset_in_stream", in_stream, 0);
    chk("reset_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load(vecs[i]);
      frame(vecs[i]);
      if (rx_q.size() > 0) readback();
      if (vecs[i].prot) begin
        quiet = 1'b1;
        repeat (10) begin
          @(negedge clk);
          if (start || busy || done || err) quiet = 1'b0;
        end
        chk("single_done_quiet", quiet, 1);
      end
    end
    load(vecs[0]);
    go = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("rst_seq_c1_word", in_stream, 32'h11);
    ready = 1'b0;
    @(negedge clk);
    chk("rst_seq_c2_word", in_stream, 32'h22);
    reset = 1'b0;
    #1;
    chk("midframe_reset_ctrl", {start, busy, done, err, err_code}, 0);
    chk("midframe_reset_in_stream", in_stream, 0);
    chk("midframe_reset_rd_data", rd_data, 0);
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b1;
    frame(vecs[0]);
    readback();
    @(negedge clk);
    go = 1'b1;
    ready = 1'b0;
    saw_err = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      go = 1'b0;
`ifdef NTT_DRV_TIMEOUT_EN
      if (t <= 8) chk("wd_arm_start", start, 1);
      if (t == 9) begin
        chk("wd_err", err, 1);
        chk("wd_code", err_code, 2);
        chk("wd_start", start, 0);
        chk("wd_busy", busy, 0);
      end
`else
      if (err) saw_err = 1'b1;
      if (t == 20) begin
        chk("hold_start", start, 1);
        chk("hold_busy", busy, 1);
        chk("hold_no_err", saw_err, 0);
      end
`endif
    end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
